bcd_scan_display: RTL and testbench

//  Drives an 8-digit common-anode 7-segment display from the 32-bit packed BCD count word (digit i = count[4i+3:4i]).

---
 rtl/bcd_scan_display_if.sv | 24 ++
 rtl/bcd_scan_display.sv | 118 +++++++++++
 tb/tb_bcd_scan_display.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Display-side bundle: BCD count word and display controls in, multiplexed 7-segment drive out.
// Latency: none (wires only).
// Backpressure: none; the display consumes the count every cycle.
interface bcd_scan_display_if;
    logic [31:0] count;
    logic        blank_lz;
    logic        edit_en;
    logic [2:0]  edit_sel;
    logic [7:0]  dp_sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output count, blank_lz, edit_en, edit_sel, dp_sel,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  count, blank_lz, edit_en, edit_sel, dp_sel,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with blanking, LZ suppression and edit blink.
// Latency: 1 clk from count/controls/scan state to an/seg/dp.
// Backpressure: none; scans free-running and samples its inputs every cycle.
module bcd_scan_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst,
    bcd_scan_display_if.slave disp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    logic             slot_tick;
    logic [3:0]       digit;
    logic [7:0]       upper_zero;
    logic             edit_hit;
    logic             blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            digit_idx <= 3'd0;
        end else if (slot_tick) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // Leaving edit mode parks the blink at the start of its visible half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!disp.edit_en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (disp.frame_tick) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 1'b1;
            end
        end
    end

    // upper_zero[i]: digits i..7 are all zero, i.e. digit i is a leading zero.
    always_comb begin
        logic z;
        z          = 1'b1;
        upper_zero = '0;
        for (int i = 7; i >= 0; i--) begin
            z             = z && (disp.count[4*i +: 4] == 4'd0);
            upper_zero[i] = z;
        end
    end

    always_comb begin
        digit    = disp.count[{digit_idx, 2'b00} +: 4];
        edit_hit = disp.edit_en && (disp.edit_sel == digit_idx);
        blank    = (div_cnt < BLANK_LIM)
                 || (disp.blank_lz && (digit_idx != 3'd0) && upper_zero[digit_idx] && !edit_hit)
                 || (edit_hit && blink_phase);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp.an         <= 8'hFF;
            disp.seg        <= 7'h7F;
            disp.dp         <= 1'b1;
            disp.frame_tick <= 1'b0;
        end else begin
            disp.frame_tick <= slot_tick && (digit_idx == 3'd7);
            if (blank) begin
                disp.an  <= 8'hFF;
                disp.seg <= 7'h7F;
                disp.dp  <= 1'b1;
            end else begin
                disp.an  <= ~(8'b1 << digit_idx);
                disp.seg <= decode(digit);
                disp.dp  <= ~disp.dp_sel[digit_idx];
            end
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised scoreboard bench for bcd_scan_display against an arithmetic reference of the scan timeline.
module tb_bcd_scan_display;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = 8 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_scan_display_if dif ();

    bcd_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif.slave)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // k: clock edges since reset release; s: first edge of the current edit_en run (-1 if none).
    function automatic exp_t model(input int k, input int s, input logic [31:0] cnt, input logic lz,
                                   input logic ee, input logic [2:0] es, input logic [7:0] dps);
        exp_t e;
        int   idx, div, nb, lo, d;
        bit   allz, hit, ph, blank;
        div = k % SD;
        idx = (k / SD) % 8;
        e.ft = ((k % FRAME) == FRAME - 1);
        nb = 0;
        if (s >= 0) begin
            lo = (s > FRAME) ? s : FRAME;
            if (k - 1 >= lo) nb = (k - 1) / FRAME - (lo - 1) / FRAME;
        end
        ph = ((nb / BF) % 2) == 1;
        allz = 1'b1;
        for (int j = idx; j < 8; j++) if (cnt[4*j +: 4] != 4'd0) allz = 1'b0;
        hit = ee && (int'(es) == idx);
        blank = (div < BC) || (lz && idx != 0 && allz && !hit) || (hit && ph);
        if (blank) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            d = int'(cnt[4*idx +: 4]);
            e.an = 8'hFF ^ (8'h01 << idx);
            e.seg = seg_of(d);
            e.dp = ~dps[idx];
        end
        return e;
    endfunction

    // Reference: one expectation per rising edge.
    initial begin
        int k;
        int s;
        k = 0;
        s = -1;
        forever begin
            @(posedge clk);
            if (!rst) begin
                k = 0;
                s = -1;
                exp_q.push_back('{8'hFF, 7'h7F, 1'b1, 1'b0});
            end else begin
                if (!dif.edit_en) s = -1;
                else if (s < 0) s = k;
                exp_q.push_back(model(k, s, dif.count, dif.blank_lz, dif.edit_en, dif.edit_sel, dif.dp_sel));
                k++;
            end
        end
    end

    // Monitor: compares on the falling edge, away from register updates.
    initial begin
        exp_t e;
        int   mc;
        int   last_ft;
        mc = 0;
        last_ft = -1;
        forever begin
            @(negedge clk);
            mc++;
            if (!rst) last_ft = -1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({dif.an, dif.seg, dif.dp, dif.frame_tick} !== {e.an, e.seg, e.dp, e.ft}) begin
                    fails++;
                    $display("FAIL scan t=%0t got an=%h seg=%b dp=%b ft=%b want an=%h seg=%b dp=%b ft=%b",
                             $time, dif.an, dif.seg, dif.dp, dif.frame_tick, e.an, e.seg, e.dp, e.ft);
                end
            end
            tests++;
            if ($countones(~dif.an) > 1) begin
                fails++;
                $display("FAIL one_hot_anode t=%0t got an=%h want at most one low bit", $time, dif.an);
            end
            if (dif.frame_tick === 1'b1) begin
                if (last_ft >= 0) begin
                    tests++;
                    if (mc - last_ft != FRAME) begin
                        fails++;
                        $display("FAIL frame_period t=%0t got %0d clks want %0d", $time, mc - last_ft, FRAME);
                    end
                end
                last_ft = mc;
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] c, input logic lz, input logic ee,
                          input logic [2:0] es, input logic [7:0] dps);
        dif.count = c; dif.blank_lz = lz; dif.edit_en = ee; dif.edit_sel = es; dif.dp_sel = dps;
    endtask

    task automatic reset_mid_slot();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({dif.an, dif.seg, dif.dp, dif.frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset got an=%h seg=%b dp=%b ft=%b want an=ff seg=1111111 dp=1 ft=0",
                     dif.an, dif.seg, dif.dp, dif.frame_tick);
        end
        hold(3);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (dif.an !== 8'hFE) begin
            fails++;
            $display("FAIL first_slot_after_reset got an=%h want an=fe", dif.an);
        end
    endtask

    initial begin
        logic [31:0] c;
        int          nz;
        set_in(32'h0, 1'b0, 1'b0, 3'd0, 8'h00);
        hold(3);
        rst = 1'b1;

        set_in(32'h87654321, 1'b0, 1'b0, 3'd0, 8'h00);
        hold(3 * FRAME + 5);
        reset_mid_slot();
        hold(FRAME);

        set_in(32'h00000123, 1'b1, 1'b0, 3'd0, 8'h00);
        hold(2 * FRAME);
        set_in(32'h00000123, 1'b0, 1'b0, 3'd0, 8'h00);
        hold(2 * FRAME);
        set_in(32'h0000000A, 1'b0, 1'b0, 3'd0, 8'h00);
        hold(FRAME);

        set_in(32'h0, 1'b1, 1'b1, 3'd5, 8'h00);
        hold(10 * FRAME + 7);
        dif.edit_en = 1'b0;
        hold(FRAME);

        set_in(32'h87654321, 1'b0, 1'b0, 3'd0, 8'h04);
        hold(2 * FRAME);

        for (int it = 0; it < 70; it++) begin
            c = '0;
            for (int j = 0; j < 8; j++)
                c[4*j +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            nz = $urandom_range(0, 8);
            for (int j = 8 - nz; j < 8; j++) c[4*j +: 4] = 4'd0;
            set_in(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                   3'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 14) == 0) reset_mid_slot();
            hold($urandom_range(1, 6 * FRAME));
        end

        hold(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
